pdm_array: RTL and testbench

//  Parametrised multi-channel density modulator, the successor to the single 5-bit PDM core.
//  It drives CHANNELS one-bit outputs, each with a complement for differential or H-bridge

---
 rtl/pdm_array_pkg.sv | 21 ++
 rtl/pdm_array_channel.sv | 55 +++++
 rtl/pdm_array.sv | 141 ++++++++++++++
 tb/tb_pdm_array.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_array_pkg.sv
// Shared constants and helpers for the multi-channel density modulator.
package pdm_array_pkg;

  localparam logic PDM_MODE_SD  = 1'b0;
  localparam logic PDM_MODE_PWM = 1'b1;

  localparam int PDM_MAX_CHANNELS = 8;
  localparam int PDM_MAX_WIDTH    = 12;
  localparam int PDM_MIN_WIDTH    = 2;

  typedef enum logic {
    CMT_IDLE    = 1'b0,
    CMT_PENDING = 1'b1
  } cmt_state_e;

  // Address/counter width that never collapses to zero bits.
  function automatic int pdm_clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pdm_array_channel.sv
// One modulator lane: sigma-delta accumulator or counter-compare, with a
// registered true/complement output pair that only moves on tick.
module pdm_array_channel
  import pdm_array_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] code_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] pwm_cnt_i,
  input  logic             clr_acc_i,
  output logic             out_o,
  output logic             out_n_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_q, out_d;
  logic             out_n_q;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, code_i};
    acc_d = acc_q;
    out_d = out_q;
    if (tick_i) begin
      if (mode_i == PDM_MODE_PWM) begin
        out_d = (pwm_cnt_i < code_i);
      end else begin
        out_d = sum[WIDTH];
        acc_d = sum[WIDTH-1:0];
      end
    end
    // A mode switch restarts the accumulator even if this is also a step.
    if (clr_acc_i) acc_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      out_q   <= 1'b0;
      out_n_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      out_q   <= out_d;
      out_n_q <= ~out_d;
    end
  end

  assign out_o   = out_q;
  assign out_n_o = out_n_q;

endmodule

// File: rtl/pdm_array.sv
// Multi-channel PDM/PWM modulator with double-buffered codes and atomic commit.
// state       | meaning
// CMT_IDLE    | no commit outstanding
// CMT_PENDING | commit requested, shadow copies to active on the next tick
module pdm_array
  import pdm_array_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DIV      = 1,
  localparam int AW      = pdm_clog2_min1(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_mode,
  input  logic                commit,
  output logic                busy,
  output logic                tick,
  output logic [CHANNELS-1:0] pdm_out,
  output logic [CHANNELS-1:0] pdm_out_n
);

  localparam int            PW       = pdm_clog2_min1(DIV);
  localparam logic [PW-1:0] PRE_LOAD = PW'(DIV - 1);

  if (CHANNELS < 1 || CHANNELS > PDM_MAX_CHANNELS) begin : g_bad_channels
    $error("pdm_array: CHANNELS out of range");
  end
  if (WIDTH < PDM_MIN_WIDTH || WIDTH > PDM_MAX_WIDTH) begin : g_bad_width
    $error("pdm_array: WIDTH out of range");
  end
  if (DIV < 1) begin : g_bad_div
    $error("pdm_array: DIV must be at least 1");
  end

  logic [PW-1:0]       pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [WIDTH-1:0]    pwm_cnt_q, pwm_cnt_d;
  cmt_state_e          state_q;
  logic                busy_q;
  logic                copy;
  logic [WIDTH-1:0]    shadow_code_q [CHANNELS];
  logic [WIDTH-1:0]    active_code_q [CHANNELS];
  logic [CHANNELS-1:0] shadow_mode_q, active_mode_q;
  logic [CHANNELS-1:0] clr_acc;

  // Down-counting prescaler; terminal count of zero reloads and fires tick.
  always_comb begin
    tick_d = (pre_q == '0);
    pre_d  = tick_d ? PRE_LOAD : pre_q - PW'(1);
  end

  assign pwm_cnt_d = tick_q ? pwm_cnt_q + WIDTH'(1) : pwm_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CMT_IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        CMT_IDLE: begin
          if (commit) begin
            state_q <= CMT_PENDING;
            busy_q  <= 1'b1;
          end
        end
        CMT_PENDING: begin
          if (tick_q) begin
            state_q <= CMT_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= CMT_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign copy    = (state_q == CMT_PENDING) && tick_q;
  assign clr_acc = {CHANNELS{copy}} & (shadow_mode_q ^ active_mode_q);

  // Active takes the pre-edge shadow, so a same-cycle write waits for a later commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_code_q[i] <= '0;
        active_code_q[i] <= '0;
      end
      shadow_mode_q <= '0;
      active_mode_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          shadow_code_q[i] <= wr_data;
          shadow_mode_q[i] <= wr_mode;
        end
        if (copy) begin
          active_code_q[i] <= shadow_code_q[i];
          active_mode_q[i] <= shadow_mode_q[i];
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pdm_array_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .tick_i    (tick_q),
      .code_i    (active_code_q[g]),
      .mode_i    (active_mode_q[g]),
      .pwm_cnt_i (pwm_cnt_q),
      .clr_acc_i (clr_acc[g]),
      .out_o     (pdm_out[g]),
      .out_n_o   (pdm_out_n[g])
    );
  end

  assign busy = busy_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_pdm_array.sv
// Bench for pdm_array: cycle scoreboard against a behavioural model (DIV=1, 3 ch)
// plus directed density, timing and reset checks, and a DIV=4 instance.
module tb_pdm_array;

  localparam int CH = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          wr_en, wr_mode, commit;
  logic [1:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          busy, tick;
  logic [CH-1:0] pdm_out, pdm_out_n;

  logic          wr_en_b, wr_mode_b, commit_b;
  logic [1:0]    wr_addr_b;
  logic [W-1:0]  wr_data_b;
  logic          busy_b, tick_b;
  logic [3:0]    pdm_out_b, pdm_out_n_b;

  pdm_array #(.CHANNELS(CH), .WIDTH(W), .DIV(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mode(wr_mode), .commit(commit), .busy(busy), .tick(tick),
    .pdm_out(pdm_out), .pdm_out_n(pdm_out_n)
  );

  pdm_array #(.CHANNELS(4), .WIDTH(W), .DIV(4)) u_dut_div4 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_mode(wr_mode_b), .commit(commit_b), .busy(busy_b), .tick(tick_b),
    .pdm_out(pdm_out_b), .pdm_out_n(pdm_out_n_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the DIV=1 instance, stepped once per cycle.
  int            m_shadow [CH];
  int            m_smode  [CH];
  int            m_active [CH];
  int            m_amode  [CH];
  int            m_acc    [CH];
  int            m_pwm;
  bit            m_pend, m_tick;
  logic [CH-1:0] m_out;
  logic [31:0]   sb_q [$];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_shadow[i] = 0; m_smode[i] = 0; m_active[i] = 0; m_amode[i] = 0; m_acc[i] = 0;
    end
    m_pwm = 0; m_pend = 0; m_tick = 0; m_out = '0;
  endtask

  task automatic model_step();
    bit            cp;
    logic [CH-1:0] nxt;
    cp  = m_pend && m_tick;
    nxt = m_out;
    if (m_tick) begin
      for (int i = 0; i < CH; i++) begin
        if (m_amode[i] == 1) begin
          nxt[i] = (m_pwm < m_active[i]);
        end else begin
          m_acc[i] = m_acc[i] + m_active[i];
          nxt[i]   = (m_acc[i] >= 256);
          m_acc[i] = m_acc[i] % 256;
        end
      end
      m_pwm = (m_pwm + 1) % 256;
    end
    if (cp) begin
      for (int i = 0; i < CH; i++) begin
        if (m_smode[i] != m_amode[i]) m_acc[i] = 0;
        m_active[i] = m_shadow[i];
        m_amode[i]  = m_smode[i];
      end
      m_pend = 0;
    end else if (commit) begin
      m_pend = 1;
    end
    if (wr_en && (int'(wr_addr) < CH)) begin
      m_shadow[wr_addr] = int'(wr_data);
      m_smode[wr_addr]  = int'(wr_mode);
    end
    m_tick = 1;
    m_out  = nxt;
    sb_q.push_back(32'({m_tick, m_pend, m_out, ~m_out}));
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
      model_reset();
    end else begin
      if (sb_q.size() > 0)
        chk("sb_cycle", 32'({tick, busy, pdm_out, pdm_out_n}), sb_q.pop_front());
      model_step();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input int d, input bit m);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = 8'(d); wr_mode = m;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step(1);
    commit = 1'b0;
  endtask

  task automatic count_hi(input int ch, input int n, output int hi, output int maxrun,
                          output int ncomp);
    int run;
    run = 0; hi = 0; maxrun = 0; ncomp = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (pdm_out[ch]) begin
        hi++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (pdm_out_n[ch] !== ~pdm_out[ch]) ncomp++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         hi, mr, nc, sum;
    bit         found;
    logic [16:0] tk, bz, po;

    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 1'b0; commit = 1'b0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; wr_mode_b = 1'b0; commit_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_a", 32'({tick, busy, pdm_out, pdm_out_n}), 32'({2'b00, 3'b000, 3'b111}));
    chk("rst_b", 32'({tick_b, busy_b, pdm_out_b, pdm_out_n_b}), 32'({2'b00, 4'h0, 4'hF}));
    @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: PDM 0x40 on ch0
    wr(0, 'h40, 1'b0);
    pulse_commit();
    @(negedge clk);
    chk("t1_busy_set", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_busy_clr", 32'(busy), 32'd0);
    @(posedge clk); #1;
    step(1);
    count_hi(0, 256, hi, mr, nc);
    chk("t1_density", 32'(hi), 32'd64);
    chk("t1_maxrun", 32'(mr), 32'd1);

    // 2: PWM 0x03 on ch1
    wr(1, 'h03, 1'b1);
    pulse_commit();
    step(3);
    count_hi(1, 256, hi, mr, nc);
    chk("t2_pwm_high", 32'(hi), 32'd3);
    chk("t2_complement", 32'(nc), 32'd0);

    // 3: shadow writes held until commit, then both lanes switch together
    wr(0, 'hFF, 1'b0);
    wr(1, 'h00, 1'b0);
    step(2);
    count_hi(0, 64, hi, mr, nc);
    chk("t3_hold_ch0", 32'(hi), 32'd16);
    pulse_commit();
    step(3);
    count_hi(0, 256, hi, mr, nc);
    chk("t3_ch0_ff", 32'(hi), 32'd255);
    count_hi(1, 256, hi, mr, nc);
    chk("t3_ch1_zero", 32'(hi), 32'd0);

    // 5: out-of-range write ignored; write during copy deferred
    wr(3, 'hAA, 1'b0);
    pulse_commit();
    step(3);
    count_hi(2, 64, hi, mr, nc);
    chk("t5_oob", 32'(hi), 32'd0);
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    wr(2, 'h80, 1'b0);
    step(2);
    count_hi(2, 64, hi, mr, nc);
    chk("t5_deferred", 32'(hi), 32'd0);
    pulse_commit();
    step(3);
    count_hi(2, 64, hi, mr, nc);
    chk("t5_second_commit", 32'(hi), 32'd32);

    // 6: asynchronous reset with a commit outstanding
    pulse_commit();
    #1;
    chk("t6_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_async", 32'({tick, busy, pdm_out, pdm_out_n}), 32'({2'b00, 3'b000, 3'b111}));
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(2);
    sum = 0;
    for (int c = 0; c < CH; c++) begin
      count_hi(c, 64, hi, mr, nc);
      sum += hi;
    end
    chk("t6_quiet", 32'(sum), 32'd0);

    // 4: DIV=4 instance, commit one cycle after a tick
    wr_en_b = 1'b1; wr_addr_b = 2'd0; wr_data_b = 8'h80; wr_mode_b = 1'b0;
    step(1);
    wr_en_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (tick_b) found = 1'b1;
    end
    chk("t4_tick_seen", 32'(found), 32'd1);
    tk = '0; bz = '0; po = '0;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      #1;
      commit_b = (j == 1);
      @(negedge clk);
      tk[j] = tick_b;
      bz[j] = busy_b;
      po[j] = pdm_out_b[0];
    end
    commit_b = 1'b0;
    chk("t4_tick_spacing", 32'(tk), 32'h11110);
    chk("t4_busy_window", 32'(bz), 32'h0001C);
    chk("t4_out_steps", 32'(po), 32'h1E000);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
